reg_write_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares the 8-bit register-write path of the Never8 register bank between several requesters.
- Accepts level-sensitive write requests (address + data) and grants one at a time.
- Drives a one-hot enable vector and a shared 8-bit data bus into a bank of 8-bit enable-gated registers.
- Returns a one-cycle completion pulse to the winner.

---
 rtl/reg_write_arbiter.sv | 102 ++++++++++
 tb/tb_reg_write_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin sequencer sharing the register-bank write path between NUM_REQ requesters.
// Each transaction is grant -> one-cycle enable strobe -> done/ack, three clocks in total.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]      req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [NUM_REGS-1:0]       reg_enable,
    output logic [7:0]                reg_datain,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, STROBE, ACK} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    rr_ptr, win, win_q;
    logic                win_vld;
    logic [ADDR_W-1:0]   addr_q, win_addr;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = PTR_W'(idx);
            end
        end
    end

    assign win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = STROBE;
            STROBE:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt        <= '0;
            done       <= '0;
            err        <= 1'b0;
            reg_enable <= '0;
            reg_datain <= 8'h00;
            busy       <= 1'b0;
            rr_ptr     <= '0;
            win_q      <= '0;
            addr_q     <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt        <= NUM_REQ'(1) << win;
                        win_q      <= win;
                        addr_q     <= win_addr;
                        reg_datain <= req_data[int'(win)*8 +: 8];
                        // Out-of-range targets still complete, but never strobe a register.
                        reg_enable <= (int'(win_addr) < NUM_REGS) ? (NUM_REGS'(1) << win_addr) : '0;
                    end
                end
                STROBE: begin
                    reg_enable <= '0;
                    done       <= gnt;
                    err        <= (int'(addr_q) >= NUM_REGS);
                end
                ACK: begin
                    done   <= '0;
                    err    <= 1'b0;
                    gnt    <= '0;
                    rr_ptr <= (int'(win_q) == NUM_REQ - 1) ? '0 : PTR_W'(int'(win_q) + 1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed table, hand sequences,
// and random requesters against a transaction-scheduling reference model.
module tb_reg_write_arbiter;

    localparam int NR = 4;
    localparam int NG = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*3-1:0] req_addr;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0] gnt, done;
    logic          err, busy;
    logic [NG-1:0] reg_enable;
    logic [7:0]    reg_datain;

    logic [2:0] a [NR];
    logic [7:0] d [NR];
    logic [7:0] bank [NG];
    logic [7:0] exp_bank [NG];

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(.NUM_REQ(NR), .NUM_REGS(NG), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .reg_enable(reg_enable),
        .reg_datain(reg_datain), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*3 +: 3] = a[i];
            req_data[i*8 +: 8] = d[i];
        end
    end

    // Enable-gated register bank with no reset.
    always @(posedge clk)
        for (int i = 0; i < NG; i++)
            if (reg_enable[i]) bank[i] <= reg_datain;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < NG; i++)
            chk($sformatf("%s_bank%0d", tag, i), 32'(bank[i]), 32'(exp_bank[i]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'({gnt, done, err, reg_enable, reg_datain, busy}), 32'h0);
        rst_n = 1'b1;
    endtask

    function automatic logic [NG-1:0] en_of(input logic [2:0] ad);
        return (ad < NG) ? (NG'(1) << ad) : '0;
    endfunction

    // Inputs already driven; the next rising edge is the grant edge E0.
    task automatic run_txn(input int w, input logic [2:0] ad, input logic [7:0] dt,
                           input logic [NG-1:0] exp_en, input logic exp_err, input bit drop);
        @(posedge clk); #1;
        chk("e0_gnt",  32'(gnt), 32'(NR'(1) << w));
        chk("e0_en",   32'(reg_enable), 32'(exp_en));
        chk("e0_data", 32'(reg_datain), 32'(dt));
        chk("e0_busy", 32'(busy), 32'(1));
        @(posedge clk); #1;
        chk("e1_done", 32'(done), 32'(NR'(1) << w));
        chk("e1_err",  32'(err), 32'(exp_err));
        chk("e1_en",   32'(reg_enable), 32'(0));
        chk("e1_gnt",  32'(gnt), 32'(NR'(1) << w));
        if (drop) req[w] = 1'b0;
        @(posedge clk); #1;
        chk("e2_idle", 32'({gnt, done, err, busy}), 32'(0));
        if (ad < NG) exp_bank[ad] = dt;
        chk_bank("txn");
    endtask

    typedef struct {
        int          who;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [NG-1:0] exp_en;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [NR-1:0] g;
        logic [NR-1:0] dn;
        logic          e;
        logic [NG-1:0] en;
        logic [7:0]    dat;
        logic          b;
    } out_t;

    initial begin
        vec_t vt [8];
        out_t q [$];
        out_t expo;
        bit   have_exp;
        int   ptr;
        logic [7:0] last;

        vt[0] = '{1, 3'd3, 8'hAA, 6'b001000, 1'b0};
        vt[1] = '{0, 3'd0, 8'h11, 6'b000001, 1'b0};
        vt[2] = '{2, 3'd5, 8'h55, 6'b100000, 1'b0};
        vt[3] = '{3, 3'd7, 8'h5A, 6'b000000, 1'b1};
        vt[4] = '{3, 3'd6, 8'h77, 6'b000000, 1'b1};
        vt[5] = '{2, 3'd4, 8'hC4, 6'b010000, 1'b0};
        vt[6] = '{0, 3'd1, 8'h0F, 6'b000010, 1'b0};
        vt[7] = '{1, 3'd2, 8'hF0, 6'b000100, 1'b0};
        for (int i = 0; i < NR; i++) begin a[i] = '0; d[i] = '0; end

        do_reset();

        foreach (vt[k]) begin
            a[vt[k].who]   = vt[k].addr;
            d[vt[k].who]   = vt[k].data;
            req[vt[k].who] = 1'b1;
            run_txn(vt[k].who, vt[k].addr, vt[k].data, vt[k].exp_en, vt[k].exp_err, 1'b1);
        end

        // Contention from reset: 0 first, 2 granted at E3.
        do_reset();
        a[0] = 3'd0; d[0] = 8'h11; a[2] = 3'd5; d[2] = 8'h55;
        req = 4'b0101;
        run_txn(0, 3'd0, 8'h11, en_of(3'd0), 1'b0, 1'b1);
        run_txn(2, 3'd5, 8'h55, en_of(3'd5), 1'b0, 1'b1);

        // Fairness: all requests held high continuously.
        do_reset();
        for (int i = 0; i < NR; i++) begin a[i] = 3'(i); d[i] = 8'(8'h20 + i); end
        req = 4'b1111;
        for (int n = 0; n < 5; n++)
            run_txn(n % NR, 3'(n % NR), 8'(8'h20 + n % NR), en_of(3'(n % NR)), 1'b0, 1'b0);
        req = '0;
        @(posedge clk); #1;

        // Data changes after the grant edge are ignored.
        a[3] = 3'd2; d[3] = 8'h3C; req = 4'b1000;
        @(posedge clk); #1;
        chk("stab_gnt", 32'(gnt), 32'b1000);
        d[3] = 8'hC3;
        @(posedge clk); #1;
        chk("stab_done", 32'(done), 32'b1000);
        req = '0;
        @(posedge clk); #1;
        exp_bank[2] = 8'h3C;
        chk("stab_bank", 32'(bank[2]), 32'h3C);
        chk("stab_datain", 32'(reg_datain), 32'h3C);

        // Reset during STROBE; rr_ptr must return to 0.
        do_reset();
        a[0] = 3'd1; d[0] = 8'h0F; req = 4'b0001;
        run_txn(0, 3'd1, 8'h0F, en_of(3'd1), 1'b0, 1'b1);
        a[2] = 3'd4; d[2] = exp_bank[4]; req = 4'b0100;
        @(posedge clk); #1;
        chk("rst_e0_gnt", 32'(gnt), 32'b0100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_e1_out", 32'({gnt, done, err, reg_enable, busy}), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) begin a[i] = 3'(i); d[i] = 8'(8'h40 + i); end
        req = 4'b1111;
        run_txn(0, 3'd0, 8'h40, en_of(3'd0), 1'b0, 1'b1);
        req = '0;

        // Random requesters against a transaction-level scheduler.
        do_reset();
        ptr = 0; last = 8'h00; have_exp = 1'b0;
        for (int cyc = 0; cyc < 1540; cyc++) begin
            @(negedge clk);
            if (have_exp) begin
                chk("rand_out", 32'({gnt, done, err, reg_enable, reg_datain, busy}), 32'(expo));
                chk("rand_inv", 32'((done & ~gnt) != 0 || $countones(gnt) > 1 ||
                                    $countones(reg_enable) > 1), 32'(0));
            end
            for (int i = 0; i < NR; i++) begin
                if (req[i] && done[i]) req[i] = 1'b0;
                else if (!req[i] && cyc < 1500 && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    a[i] = 3'($urandom_range(0, 7));
                    d[i] = 8'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    a[i] = 3'($urandom_range(0, 7));
                    d[i] = 8'($urandom);
                end
            end
            if (q.size() == 0) begin
                int w;
                w = -1;
                for (int k = 0; k < NR; k++)
                    if (w < 0 && req[(ptr + k) % NR]) w = (ptr + k) % NR;
                if (w >= 0) begin
                    logic bad;
                    bad  = (a[w] >= NG);
                    last = d[w];
                    q.push_back('{NR'(1) << w, '0, 1'b0, en_of(a[w]), d[w], 1'b1});
                    q.push_back('{NR'(1) << w, NR'(1) << w, bad, '0, d[w], 1'b1});
                    q.push_back('{'0, '0, 1'b0, '0, d[w], 1'b0});
                    if (!bad) exp_bank[a[w]] = d[w];
                    ptr = (w + 1) % NR;
                end
            end
            if (q.size() != 0) expo = q.pop_front();
            else               expo = '{'0, '0, 1'b0, '0, last, 1'b0};
            have_exp = 1'b1;
        end
        @(negedge clk);
        chk_bank("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
